snitch_mem_adapter: RTL

SNITCH_MEM_ADAPTER -- requirements
Module: snitch_mem_adapter

---
 rtl/snitch_pkg.sv | 21 ++
 rtl/snitch_sync_fifo.sv | 74 +++++++
 rtl/snitch_mem_adapter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/snitch_pkg.sv
// Shared Snitch data-port payload types and default widths.
package snitch_pkg;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 write;
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
   } dreq_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic                 write;
      logic                 error;
   } dresp_t;

endpackage

// File: rtl/snitch_sync_fifo.sv
// Fall-through synchronous FIFO: a pushed entry is visible on data_o in the same cycle.
module snitch_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     data_i,
   output logic valid_o,
   input  logic pop_i,
   output T     data_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   T                mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            empty;
   logic            full;
   logic            bypass;
   logic            store;
   logic            drain;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntW'(DEPTH));
   assign valid_o = !empty || push_i;
   assign data_o  = empty ? data_i : mem_q[rd_ptr_q];

   // Push into an empty FIFO that is popped in the same cycle never gets stored.
   assign bypass = empty && push_i && pop_i;
   assign store  = push_i && !bypass;
   assign drain  = pop_i && !empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (store) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (drain) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (store && !drain) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (drain && !store) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (store) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_i && full && !pop_i));
      end
   end

endmodule

// File: rtl/snitch_mem_adapter.sv
// Bridges a valid/ready data request stream onto a fixed-latency SRAM bank and
// returns in-order single-beat responses through a fall-through buffer.
module snitch_mem_adapter
   import snitch_pkg::*;
#(
   parameter type                   req_t        = snitch_pkg::dreq_t,
   parameter type                   resp_t       = snitch_pkg::dresp_t,
   parameter int unsigned           DataWidth    = snitch_pkg::DataWidth,
   parameter int unsigned           NumWords     = 1024,
   parameter int unsigned           MemLatency   = 1,
   parameter int unsigned           RespDepth    = 4,
   localparam int unsigned          StrbWidth    = DataWidth / 8,
   localparam int unsigned          MemAddrWidth = $clog2(NumWords)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  req_t                    req_payload_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   output resp_t                   resp_payload_o,
   output logic                    resp_last_o,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [MemAddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0]    mem_wdata_o,
   output logic [StrbWidth-1:0]    mem_be_o,
   input  logic [DataWidth-1:0]    mem_rdata_i
);

   localparam int unsigned OffW = $clog2(StrbWidth);
   localparam int unsigned CntW = $clog2(RespDepth + 1);

   if (MemLatency < 1) begin : gen_bad_latency
      $error("snitch_mem_adapter: MemLatency must be at least 1");
   end
   if (RespDepth < MemLatency) begin : gen_bad_depth
      $error("snitch_mem_adapter: RespDepth must be >= MemLatency");
   end

   logic [AddrWidth-1:0]  word_idx;
   logic                  in_range;
   logic                  accept;
   logic                  pop;
   logic                  fifo_valid;
   logic                  fifo_push;
   resp_t                 fifo_wdata;
   logic [CntW-1:0]       outstanding_q;
   logic [CntW-1:0]       outstanding_d;
   logic [MemLatency-1:0] pipe_valid_q;
   logic [MemLatency-1:0] pipe_write_q;
   logic [MemLatency-1:0] pipe_error_q;

   assign word_idx = req_payload_i.addr >> OffW;
   assign in_range = (word_idx < AddrWidth'(NumWords));

   // Space is guaranteed when an entry leaves in the same cycle one is accepted.
   assign pop          = resp_valid_o && resp_ready_i;
   assign req_ready_o  = rst_i || (outstanding_q < CntW'(RespDepth)) || pop;
   assign accept       = req_valid_i && req_ready_o && !rst_i;
   assign resp_valid_o = fifo_valid && !rst_i;
   assign resp_last_o  = 1'b1;

   assign mem_req_o   = accept && in_range;
   assign mem_we_o    = req_payload_i.write;
   assign mem_addr_o  = word_idx[MemAddrWidth-1:0];
   assign mem_wdata_o = req_payload_i.data;
   assign mem_be_o    = req_payload_i.strb;

   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !pop) begin
         outstanding_d = outstanding_q + CntW'(1);
      end else if (pop && !accept) begin
         outstanding_d = outstanding_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   // Stage MemLatency-1 lines up with the SRAM read data of the same request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_valid_q <= '0;
      end else begin
         pipe_valid_q[0] <= accept;
         for (int unsigned i = 1; i < MemLatency; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      pipe_write_q[0] <= req_payload_i.write;
      pipe_error_q[0] <= !in_range;
      for (int unsigned i = 1; i < MemLatency; i++) begin
         pipe_write_q[i] <= pipe_write_q[i-1];
         pipe_error_q[i] <= pipe_error_q[i-1];
      end
   end

   assign fifo_push = pipe_valid_q[MemLatency-1];

   always_comb begin
      fifo_wdata       = '0;
      fifo_wdata.write = pipe_write_q[MemLatency-1];
      fifo_wdata.error = pipe_error_q[MemLatency-1];
      if (!pipe_write_q[MemLatency-1] && !pipe_error_q[MemLatency-1]) begin
         fifo_wdata.data = mem_rdata_i;
      end
   end

   snitch_sync_fifo #(
      .DEPTH (RespDepth),
      .T     (resp_t)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (fifo_wdata),
      .valid_o (fifo_valid),
      .pop_i   (pop),
      .data_o  (resp_payload_o)
   );

endmodule
